// File: rtl/instr_encode_writer.sv
// Encodes symbolic micro-ops to RV32I words and streams them into imem.
// Optional ENC_CHECK_EN: illegal immediates become NOP and set sticky err_o.
module instr_encode_writer #(
  parameter int AW = 10,
  parameter int DEPTH = 4,
  parameter int MAX_WORDS = 256,
  localparam int WW = $clog2(MAX_WORDS + 1)
) (
  input  logic          clk_i,
  input  logic          rst_n,
  input  logic          start_i,
  input  logic [AW-1:0] base_addr_i,
  input  logic          finish_i,
  input  logic          req_valid_i,
  output logic          req_ready_o,
  input  logic [2:0]    req_op_i,
  input  logic [4:0]    req_rd_i,
  input  logic [4:0]    req_rs1_i,
  input  logic [4:0]    req_rs2_i,
  input  logic [12:0]   req_imm_i,
  output logic          imem_we_o,
  output logic [AW-1:0] imem_addr_o,
  output logic [31:0]   imem_wdata_o,
  output logic          busy_o,
  output logic          done_o,
  output logic [WW-1:0] words_o,
  output logic          err_o
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [31:0]   mem [DEPTH];
  logic [PW:0]   wr_ptr_q, rd_ptr_q;
  logic [AW-1:0] addr_q;
  logic [WW-1:0] acc_q;
  logic          full, empty, push, pop;
  logic          ready;
  logic [31:0]   raw_word, enc_word;
  logic          enc_bad;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                 (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);

  always_comb begin
    raw_word = NOP;
    unique case (req_op_i)
      3'd0: raw_word = {7'h00, req_rs2_i, req_rs1_i, 3'b000,
                        req_rd_i, 7'h33};
      3'd1: raw_word = {7'h20, req_rs2_i, req_rs1_i, 3'b000,
                        req_rd_i, 7'h33};
      3'd2: raw_word = {7'h00, req_rs2_i, req_rs1_i, 3'b111,
                        req_rd_i, 7'h33};
      3'd3: raw_word = {7'h00, req_rs2_i, req_rs1_i, 3'b110,
                        req_rd_i, 7'h33};
      3'd4: raw_word = {req_imm_i[11:0], req_rs1_i, 3'b010,
                        req_rd_i, 7'h03};
      3'd5: raw_word = {req_imm_i[11:5], req_rs2_i, req_rs1_i,
                        3'b010, req_imm_i[4:0], 7'h23};
      3'd6: raw_word = {req_imm_i[12], req_imm_i[10:5], req_rs2_i,
                        req_rs1_i, 3'b000, req_imm_i[4:1],
                        req_imm_i[11], 7'h63};
      3'd7: raw_word = NOP;
      default: raw_word = NOP;
    endcase
  end

`ifdef ENC_CHECK_EN
  assign enc_bad = ((req_op_i == 3'd6) && req_imm_i[0]) ||
                   (((req_op_i == 3'd4) || (req_op_i == 3'd5)) &&
                    (req_imm_i[12] != req_imm_i[11]));
`else
  assign enc_bad = 1'b0;
`endif

  assign enc_word = enc_bad ? NOP : raw_word;

  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    done_o  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) state_d = S_RUN;
      end
      S_RUN: begin
        ready = !full && (acc_q < WW'(MAX_WORDS));
        if (finish_i || (acc_q == WW'(MAX_WORDS))) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        // wait until the last popped word has been presented to imem
        if (empty && !imem_we_o) state_d = S_DONE;
      end
      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign req_ready_o = ready;
  assign busy_o      = (state_q != S_IDLE);
  assign push        = ready && req_valid_i;
  assign pop         = ((state_q == S_RUN) || (state_q == S_DRAIN)) && !empty;

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr_q[PW-1:0]] <= enc_word;
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      addr_q       <= '0;
      acc_q        <= '0;
      words_o      <= '0;
      err_o        <= 1'b0;
      imem_we_o    <= 1'b0;
      imem_addr_o  <= '0;
      imem_wdata_o <= '0;
    end else begin
      state_q   <= state_d;
      imem_we_o <= pop;
      if ((state_q == S_IDLE) && start_i) begin
        addr_q  <= {base_addr_i[AW-1:2], 2'b00};
        acc_q   <= '0;
        words_o <= '0;
        err_o   <= 1'b0;
      end
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
        acc_q    <= acc_q + 1'b1;
        if (enc_bad) err_o <= 1'b1;
      end
      if (pop) begin
        rd_ptr_q     <= rd_ptr_q + 1'b1;
        imem_addr_o  <= addr_q;
        imem_wdata_o <= mem[rd_ptr_q[PW-1:0]];
        addr_q       <= addr_q + AW'(4);
        words_o      <= words_o + 1'b1;
      end
    end
  end

endmodule
